// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM read arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam int unsigned DefAddrW = 3;
  localparam int unsigned DefDataW = 16;

  // Width of a requester index; never below one bit so single-bit selects stay legal.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin search: first set request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Walk the requests starting at ptr and take the first one found.
  always_comb begin
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j[ID_W-1:0]]) begin
        any                 = 1'b1;
        idx                 = j[ID_W-1:0];
        gnt[j[ID_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin shared-ROM read sequencer: grant, look up, hold response until accepted.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                owner_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Mux the winner's address and the owner's accept bit with constant-index loops.
  always_comb begin
    gnt_addr    = '0;
    owner_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
      if (id_q == ID_W'(i))    owner_ready = rsp_ready[i];
    end
  end

  // Next-state logic and output decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    req_ready  = '0;
    rsp_valid  = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so grants stay low while reset is held.
        req_ready = rst_n ? gnt : '0;
        if (gnt_any) begin
          addr_d   = gnt_addr;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d  = StLookup;
        end
      end
      StLookup: begin
        rsp_data_d = rom_data;
        state_d    = StResp;
      end
      StResp: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          rsp_valid[i] = (id_q == ID_W'(i));
        end
        if (owner_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rom_addr = addr_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: directed scenarios plus random traffic.
module tb_rom_read_arbiter;

  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;

  assign rom_data = 16'hA000 | 16'(rom_addr);

  always #5 clk = ~clk;

  rom_read_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  exp_t          cur;
  bit            cur_valid = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  // Reference model: 0 = waiting for a grant, 1 = reading, 2 = responding.
  int            m_phase = 0;
  int            m_ptr = 0;
  int            m_id = 0;
  logic [AW-1:0] m_addr = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model advances on each clock edge; reset flushes everything at once.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase   = 0;
        m_ptr     = 0;
        m_id      = 0;
        m_addr    = '0;
        cur_valid = 0;
        sbq.delete();
      end else begin
        if (cur_valid && rsp_ready[cur.id]) cur_valid = 0;
        case (m_phase)
          0: begin
            int w;
            w = pick(req_valid, m_ptr);
            if (w >= 0) begin
              m_addr  = req_addr[w*AW +: AW];
              m_id    = w;
              m_ptr   = (w + 1) % N;
              sbq.push_back('{id: w, data: 16'hA000 | 16'(m_addr), due: cyc + 2});
              m_phase = 1;
            end
          end
          1: m_phase = 2;
          default: if (rsp_ready[m_id]) m_phase = 0;
        endcase
        cyc++;
      end
    end
  end

  // Monitor: checks grants and address every cycle, pops expected responses as they appear.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
      end else begin
        logic [N-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        w = pick(req_valid, m_ptr);
        if (m_phase == 0 && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        if (rsp_valid != '0) begin
          if (!cur_valid) begin
            if (sbq.size() == 0) begin
              fail_now("rsp_spurious");
            end else begin
              cur       = sbq.pop_front();
              cur_valid = 1;
              chk("rsp_latency", 32'(cyc), 32'(cur.due));
            end
          end
          if (cur_valid) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << cur.id);
            chk("rsp_data", 32'(rsp_data), 32'(cur.data));
          end
        end else if (cur_valid) begin
          fail_now("rsp_dropped_early");
          cur_valid = 0;
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          fail_now("rsp_missing");
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset held with both requesters valid.
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready", 32'(req_ready), 0);
    step(3);
    rst_n     = 1'b1;
    req_valid = '0;
    step(2);

    // Single read of address 6 by requester 0.
    rsp_ready        = 2'b11;
    req_addr[0 +: AW] = 3'h6;
    req_valid        = 2'b01;
    #1;
    chk("single_grant", 32'(req_ready), 32'b01);
    step(1);
    req_valid = '0;
    step(5);

    // Contention: both continuously valid.
    req_addr[0 +: AW]  = 3'h1;
    req_addr[AW +: AW] = 3'h7;
    req_valid          = 2'b11;
    step(12);
    req_valid = '0;
    step(4);

    // Response stall on requester 1; requester 0 waits and its accept bit is ignored.
    rsp_ready          = 2'b01;
    req_addr[AW +: AW] = 3'h0;
    req_valid          = 2'b10;
    step(1);
    req_addr[0 +: AW] = 3'h3;
    req_valid         = 2'b01;
    step(7);
    rsp_ready = 2'b11;
    step(6);
    req_valid = '0;
    step(4);

    // Withdrawn request: requester 0 pulses while requester 1 is in its response phase.
    rsp_ready          = 2'b00;
    req_addr[AW +: AW] = 3'h4;
    req_valid          = 2'b10;
    step(1);
    req_valid = '0;
    step(2);
    req_valid = 2'b01;
    step(1);
    req_valid = '0;
    step(2);
    rsp_ready = 2'b11;
    step(2);
    req_valid = 2'b11;
    #1;
    chk("after_skip_grant", 32'(req_ready), 32'b01);
    step(1);
    req_valid = '0;
    step(8);

    // Reset in the middle of a lookup of address 5.
    req_addr[0 +: AW] = 3'h5;
    req_valid         = 2'b01;
    step(1);
    req_valid = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rom_addr", 32'(rom_addr), 0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("async_rst_rsp_data", 32'(rsp_data), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    req_addr[0 +: AW]  = 3'h2;
    req_addr[AW +: AW] = 3'h2;
    req_valid          = 2'b11;
    #1;
    chk("post_reset_first_grant", 32'(req_ready), 32'b01);
    step(1);
    req_valid = '0;
    step(5);

    // Random traffic honouring the hold-until-granted rule via withdraw-or-keep.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 4) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          req_valid[i]        = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      rsp_ready = N'($urandom);
      step(1);
    end
    req_valid = '0;
    rsp_ready = 2'b11;
    step(8);

    chk("scoreboard_empty", 32'(sbq.size()), 0);
    chk("no_pending_rsp", 32'(cur_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
